// File: rtl/seg_display_rx.sv
// Receive side of a multiplexed, active-low 4-digit seven-segment display:
// samples anode/cathode lines and rebuilds the shown number as BCD and binary.
module seg_display_rx #(
    parameter int unsigned SETTLE_CYCLES  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 4194304
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [3:0]  digits,
    input  logic [6:0]  segments,
    output logic [15:0] bcd,
    output logic [13:0] value,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        stale
);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_CAP = SW'(SETTLE_CYCLES - 2);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_HIT    = TW'(TIMEOUT_CYCLES - 1);

    logic [3:0]    dig_s1, dig_s2, dig_prev;
    logic [6:0]    seg_s1, seg_s2, seg_prev;
    logic [SW-1:0] settle_cnt, settle_next;
    logic [TW-1:0] to_cnt, to_next;
    logic [15:0]   stage;
    logic [3:0]    mask, mask_next;
    logic          acc, acc_next;
    logic          done, done_next;

    logic          anode_valid, changed, capture, timeout_hit;
    logic [1:0]    slot;
    logic [3:0]    slot_bit;
    logic [4:0]    dec;
    logic [13:0]   frame_value;

    // {undecodable, nibble} for one active-low g..a pattern
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = 5'h00;
            7'b1111001: r = 5'h01;
            7'b0100100: r = 5'h02;
            7'b0110000: r = 5'h03;
            7'b0011001: r = 5'h04;
            7'b0010010: r = 5'h05;
            7'b0000010: r = 5'h06;
            7'b1111000: r = 5'h07;
            7'b0000000: r = 5'h08;
            7'b0011000: r = 5'h09;
            default:    r = 5'h1F;
        endcase
        return r;
    endfunction

    // Exactly one low anode selects a staging slot
    always_comb begin
        slot        = 2'd0;
        slot_bit    = 4'b0000;
        anode_valid = 1'b1;
        case (dig_s2)
            4'b1110: begin slot = 2'd0; slot_bit = 4'b0001; end
            4'b1101: begin slot = 2'd1; slot_bit = 4'b0010; end
            4'b1011: begin slot = 2'd2; slot_bit = 4'b0100; end
            4'b0111: begin slot = 2'd3; slot_bit = 4'b1000; end
            default: anode_valid = 1'b0;
        endcase
    end

    always_comb begin
        dec         = decode(seg_s2);
        changed     = (dig_s2 != dig_prev) || (seg_s2 != seg_prev);
        capture     = anode_valid && !changed && (settle_cnt == SETTLE_CAP);
        timeout_hit = !capture && (to_cnt == TMO_HIT);

        settle_next = settle_cnt;
        if (changed || !anode_valid)
            settle_next = '0;
        else if (settle_cnt != SETTLE_MAX)
            settle_next = settle_cnt + SW'(1);

        to_next = to_cnt;
        if (capture)
            to_next = '0;
        else if (to_cnt != TMO_MAX)
            to_next = to_cnt + TW'(1);

        // A frame finishing this cycle hands over an empty mask to any new capture
        mask_next = (done ? 4'b0000 : mask) | (capture ? slot_bit : 4'b0000);
        acc_next  = (done ? 1'b0 : acc) | (capture & dec[4]);
        done_next = capture && (mask_next == 4'b1111);
        if (timeout_hit) begin
            mask_next = 4'b0000;
            acc_next  = 1'b0;
        end

        frame_value = 14'(stage[15:12]) * 14'd1000 + 14'(stage[11:8]) * 14'd100
                    + 14'(stage[7:4]) * 14'd10 + 14'(stage[3:0]);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            dig_s1      <= '0;
            dig_s2      <= '0;
            dig_prev    <= '0;
            seg_s1      <= '0;
            seg_s2      <= '0;
            seg_prev    <= '0;
            settle_cnt  <= '0;
            to_cnt      <= '0;
            stage       <= '0;
            mask        <= '0;
            acc         <= 1'b0;
            done        <= 1'b0;
            bcd         <= '0;
            value       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            stale       <= 1'b0;
        end else begin
            dig_s1     <= digits;
            dig_s2     <= dig_s1;
            dig_prev   <= dig_s2;
            seg_s1     <= segments;
            seg_s2     <= seg_s1;
            seg_prev   <= seg_s2;
            settle_cnt <= settle_next;
            to_cnt     <= to_next;
            mask       <= mask_next;
            acc        <= acc_next;
            done       <= done_next;
            if (capture)
                stage[{slot, 2'b00} +: 4] <= dec[3:0];

            frame_valid <= done;
            if (done) begin
                bcd       <= stage;
                frame_err <= acc;
                if (!acc)
                    value <= frame_value;
            end

            if (done)
                stale <= 1'b0;
            else if (timeout_hit)
                stale <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seg_display_rx.sv
// Randomized bench for seg_display_rx: a run-length input model predicts each
// completed frame; a compare process checks the outputs every cycle.
module tb_seg_display_rx;
    localparam int unsigned SETTLE = 16;
    localparam int unsigned TMO    = 1000;

    typedef struct packed {
        logic [15:0] bcd;
        logic [13:0] value;
        logic        err;
    } frame_t;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [3:0]  digits   = 4'hF;
    logic [6:0]  segments = 7'h7F;
    logic [15:0] bcd;
    logic [13:0] value;
    logic        frame_valid, frame_err, stale;

    seg_display_rx #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(clk), .reset(reset), .digits(digits), .segments(segments),
        .bcd(bcd), .value(value), .frame_valid(frame_valid),
        .frame_err(frame_err), .stale(stale)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, fv_count = 0, fv_cycle = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

    // Model: input runs, staging slots, expected frame queue
    frame_t     exp_q[$];
    logic [3:0] run_dig = 4'h0;
    logic [6:0] run_seg = 7'h00;
    int         run_len = 0;
    bit         run_cap = 0;
    logic [3:0] m_nib [4];
    bit         m_seen [4];
    bit         m_err = 0;
    logic [13:0] m_value = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int decode_model(input logic [6:0] s);
        for (int i = 0; i < 10; i++)
            if (seg_tab[i] == s) return i;
        return 15;
    endfunction

    task automatic model_capture(input logic [3:0] d, input logic [6:0] s);
        int slot = 0;
        int nib;
        frame_t f;
        for (int i = 0; i < 4; i++) if (!d[i]) slot = i;
        nib = decode_model(s);
        m_nib[slot]  = 4'(nib);
        m_seen[slot] = 1;
        if (nib == 15) m_err = 1;
        if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
            f.bcd = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
            f.err = m_err;
            if (!m_err)
                m_value = 14'(int'(m_nib[3]) * 1000 + int'(m_nib[2]) * 100
                              + int'(m_nib[1]) * 10 + int'(m_nib[0]));
            f.value = m_value;
            exp_q.push_back(f);
            for (int i = 0; i < 4; i++) m_seen[i] = 0;
            m_err = 0;
        end
    endtask

    // One cycle of input; a run of SETTLE identical cycles on one low anode is a capture
    task automatic tick(input logic [3:0] d, input logic [6:0] s);
        digits   = d;
        segments = s;
        if (d == run_dig && s == run_seg) run_len++;
        else begin
            run_dig = d; run_seg = s; run_len = 1; run_cap = 0;
        end
        if ($countones(~d) == 1 && run_len == SETTLE && !run_cap) begin
            run_cap = 1;
            model_capture(d, s);
        end
        @(posedge clk); #1;
    endtask

    task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
        repeat (n) tick(d, s);
    endtask

    task automatic show_digit(input int slot, input logic [6:0] s, input int n);
        logic [3:0] a;
        a = 4'(1 << slot);
        hold(~a, s, n);
    endtask

    task automatic show_num(input int num, input int dwell);
        show_digit(3, seg_tab[(num / 1000) % 10], dwell);
        show_digit(2, seg_tab[(num / 100) % 10], dwell);
        show_digit(1, seg_tab[(num / 10) % 10], dwell);
        show_digit(0, seg_tab[num % 10], dwell);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; digits = 4'hF; segments = 7'h7F;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
        run_dig = 4'h0; run_seg = 7'h00; run_len = 0; run_cap = 0;
        for (int i = 0; i < 4; i++) begin m_seen[i] = 0; m_nib[i] = 4'h0; end
        m_err = 0; m_value = 0;
        exp_q.delete();
    endtask

    task automatic glitch();
        logic [3:0] a;
        case ($urandom_range(0, 3))
            0: ;
            1: hold(4'hF, 7'($urandom), $urandom_range(1, 10));
            2: show_digit($urandom_range(0, 3), 7'($urandom), $urandom_range(1, SETTLE - 4));
            default: begin
                a = 4'($urandom);
                if ($countones(~a) < 2) a = 4'b0000;
                hold(a, 7'($urandom), $urandom_range(1, 60));
            end
        endcase
    endtask

    // Compare process: expected outputs change only on frame_valid
    bit          started = 0;
    bit          rs;
    frame_t      e;
    logic [15:0] cur_bcd = 0;
    logic [13:0] cur_value = 0;
    logic        cur_err = 0;
    initial begin
        forever begin
            @(posedge clk); rs = reset;
            @(negedge clk);
            if (rs) begin
                started = 1;
                chk("rst_bcd", bcd, 0);
                chk("rst_value", value, 0);
                chk("rst_frame_valid", frame_valid, 0);
                chk("rst_frame_err", frame_err, 0);
                chk("rst_stale", stale, 0);
                cur_bcd = 0; cur_value = 0; cur_err = 0;
            end else if (started) begin
                if (frame_valid === 1'b1) begin
                    fv_count++;
                    fv_cycle = cyc;
                    if (exp_q.size() == 0) chk("unexpected_frame_valid", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        cur_bcd = e.bcd; cur_value = e.value; cur_err = e.err;
                    end
                    chk("stale_on_frame", stale, 0);
                end
                chk("bcd", bcd, cur_bcd);
                chk("value", value, cur_value);
                chk("frame_err", frame_err, cur_err);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    int f0;
    int dg [4];
    int ord [4];
    int j, t;
    logic [6:0] p;
    initial begin
        do_reset(4);

        // Two scans of 1234
        f0 = fv_count;
        show_num(1234, 64); show_num(1234, 64); hold(4'hF, 7'h7F, 20);
        chk("t1_frames", fv_count - f0, 2);
        chk("t1_bcd", bcd, 16'h1234);
        chk("t1_value", value, 1234);
        chk("t1_err", frame_err, 0);

        // Undecodable ones digit, then a clean 0999
        show_digit(3, seg_tab[5], 64); show_digit(2, seg_tab[6], 64);
        show_digit(1, seg_tab[7], 64); show_digit(0, 7'b1111111, 64);
        hold(4'hF, 7'h7F, 20);
        chk("t2_bcd", bcd, 16'h567F);
        chk("t2_err", frame_err, 1);
        chk("t2_value_hold", value, 1234);
        show_num(999, 64); hold(4'hF, 7'h7F, 20);
        chk("t2_value", value, 999);
        chk("t2_bcd_clean", bcd, 16'h0999);
        chk("t2_err_clean", frame_err, 0);

        // Multi-low anode and short dwells never capture
        f0 = fv_count;
        hold(4'b0011, seg_tab[8], 100);
        for (int s = 0; s < 4; s++) begin
            show_digit(s, seg_tab[s + 1], 10);
            hold(4'hF, 7'h7F, 5);
        end
        chk("t3_no_frame", fv_count - f0, 0);
        show_digit(0, seg_tab[6], 64); show_digit(1, seg_tab[7], 64);
        show_digit(2, seg_tab[8], 64); show_digit(3, seg_tab[9], 64);
        hold(4'hF, 7'h7F, 20);
        chk("t3_frames", fv_count - f0, 1);
        chk("t3_value", value, 9876);
        chk("t3_bcd", bcd, 16'h9876);

        // Stale after TMO cycles without capture, cleared by next frame
        while (cyc < fv_cycle + int'(TMO) - 10) tick(4'hF, 7'h7F);
        chk("t4_not_stale_yet", stale, 0);
        while (cyc < fv_cycle + int'(TMO) + 10) tick(4'hF, 7'h7F);
        chk("t4_stale", stale, 1);
        chk("t4_bcd_hold", bcd, 16'h9876);
        chk("t4_value_hold", value, 9876);
        show_num(42, 64); hold(4'hF, 7'h7F, 20);
        chk("t4_stale_clear", stale, 0);
        chk("t4_value", value, 42);
        chk("t4_bcd", bcd, 16'h0042);

        // Reset discards a partial frame
        f0 = fv_count;
        show_digit(3, seg_tab[8], 64); show_digit(2, seg_tab[8], 64);
        do_reset(3);
        chk("t5_no_partial", fv_count - f0, 0);
        chk("t5_bcd_rst", bcd, 0);
        show_num(8888, 64); hold(4'hF, 7'h7F, 20);
        chk("t5_frames", fv_count - f0, 1);
        chk("t5_bcd", bcd, 16'h8888);
        chk("t5_value", value, 8888);

        // Random frames: random order, glitches, bad patterns, re-captures
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < 4; i++) begin dg[i] = $urandom_range(0, 9); ord[i] = i; end
            for (int i = 3; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
            for (int k = 0; k < 4; k++) begin
                glitch();
                p = ($urandom_range(0, 9) == 0) ? 7'($urandom) : seg_tab[dg[ord[k]]];
                show_digit(ord[k], p, $urandom_range(SETTLE, 80));
                if (k == 2 && $urandom_range(0, 4) == 0)
                    show_digit(ord[0], seg_tab[$urandom_range(0, 9)], $urandom_range(SETTLE, 80));
            end
        end
        hold(4'hF, 7'h7F, 30);
        chk("pending_frames", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/seg_display_rx.md
Name: seg_display_rx

Overview:
- Receive end of the multiplexed 4-digit seven-segment interface: samples active-low anode (digits) and cathode (segments) lines and reconstructs the displayed number.
- Used for loopback self-test of the display path, and for reading an external multiplexed display back into the fabric.
- Outputs per-digit BCD, a binary value (0..9999), a one-cycle frame-valid strobe, and error/stale flags.

Parameters:
SETTLE_CYCLES, 1024, cycles a digit selection plus pattern must stay unchanged before it is captured (range 2..65535)
TIMEOUT_CYCLES, 4194304, cycles without any capture before the frame is declared stale

Ports:
CLK  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
digits  input  4  anode lines, active-low; bit3 = leftmost (thousands) digit, bit0 = ones
segments  input  7  cathode lines, active-low, order g..a (bit6 = g)
bcd  output  16  {thousands,hundreds,tens,ones}; an undecodable digit reads 4'hF
value  output  14  binary value of the last error-free frame
frame_valid  output  1  one-cycle pulse when bcd/value/frame_err update
frame_err  output  1  last frame contained at least one undecodable pattern
stale  output  1  no capture for TIMEOUT_CYCLES; cleared by the next frame_valid

Behaviour:
- Reset (synchronous, active-high): bcd=0, value=0, frame_valid=0, frame_err=0, stale=0. Also clears the synchronizers, settle counter, capture mask, staging registers, error accumulator and timeout counter. Reset mid-frame discards the partial frame.
- Input sync: digits and segments each pass through two flops. All logic below uses the synced values; 2-cycle input latency.
- Anode qualification: valid only if exactly one bit of synced digits is 0.
  - 4'b1111 (blank) and any multi-low value are not valid.
  - No valid anode: settle counter held at 0.
- Settle counter (width clog2(SETTLE_CYCLES)+1):
  - Resets to 0 on any cycle where synced digits or segments differ from the previous cycle.
  - Increments while the anode is valid and both buses are unchanged; saturates at SETTLE_CYCLES.
  - Capture fires on the cycle it reaches SETTLE_CYCLES-1 (exactly once per dwell).
- Capture:
  - Decoded nibble is written to the staging slot selected by the low anode, and the slot's mask bit is set.
  - A re-capture of a slot before the frame completes overwrites it (latest wins).
  - Capture resets the timeout counter.
- Decode, segments to nibble:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0011000→9.
  - Any other pattern → 4'hF and sets the frame error accumulator.
- Frame completion: on the cycle after the capture that makes mask=4'b1111:
  - frame_valid=1 for exactly one cycle.
  - bcd ← staging; frame_err ← accumulator; stale ← 0.
  - If the accumulator is 0: value ← th*1000+hu*100+te*10+on (14-bit unsigned, max 9999). Otherwise value holds.
  - mask and accumulator clear on the same edge.
  - A capture arriving on that same edge starts the new frame: its mask bit and error are set after the clear.
- Timeout counter (width clog2(TIMEOUT_CYCLES)+1):
  - Increments every cycle and saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: stale ← 1, mask and accumulator cleared. bcd and value hold.
  - Remains stale until the next complete frame.
- Capture order is free. The producer's order (thousands→ones) is not required; any order completes the frame.

Test Plan:
- Producer model, SETTLE_CYCLES=16, dwell 64 cycles per digit, showing 1234 → frame_valid pulses once per 4-digit scan; bcd=16'h1234, value=1234, frame_err=0.
- Ones digit pattern 7'b1111111, other digits 5,6,7 → bcd=16'h567F, frame_err=1, value keeps prior 1234. The next clean frame 0999 gives value=999, frame_err=0.
- Anode 4'b0011 held 100 cycles, plus glitch dwells of 10 cycles (<16) → no capture, no frame_valid. Digits then scanned in order ones, tens, hundreds, thousands showing 9876 → value=9876.
- TIMEOUT_CYCLES=1000, digits=4'b1111 after a good frame → stale=1 at 1000 cycles after the last capture; bcd/value unchanged. A full frame of 0042 → stale=0, value=42.
- Reset asserted after 2 of 4 captures, then a full 8888 frame → no frame_valid from the partial frame; first frame_valid shows bcd=16'h8888, value=8888. All outputs are 0 during reset.
